uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4,
        WAIT_HIGH    = 3'd5
    } rx_state_t;

    // Counter value at which the middle of a bit is reached, measured from its edge.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, reports good bytes and framing errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Active
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic             rx_s;
    rx_state_t        state;
    rx_state_t        next_state;
    logic [CNT_W-1:0] clk_count;
    logic [2:0]       bit_index;
    logic [7:0]       shift_reg;

    uart_rx_sync u_sync (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .async_in (i_RX_Serial),
        .sync_out (rx_s)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (!rx_s) next_state = RX_START_BIT;
            RX_START_BIT: if (clk_count == HALF_CNT) next_state = rx_s ? IDLE : RX_DATA_BITS;
            RX_DATA_BITS: if (clk_count == LAST_CNT && bit_index == LAST_BIT) next_state = RX_STOP_BIT;
            RX_STOP_BIT:  if (clk_count == LAST_CNT) next_state = rx_s ? CLEANUP : WAIT_HIGH;
            CLEANUP:      next_state = IDLE;
            // A held-low break line must rise before another start bit is looked for.
            WAIT_HIGH:    if (rx_s) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            clk_count      <= '0;
            bit_index      <= '0;
            shift_reg      <= '0;
            o_RX_Byte      <= '0;
            o_RX_DV        <= 1'b0;
            o_RX_Frame_Err <= 1'b0;
            o_RX_Active    <= 1'b0;
        end else begin
            state          <= next_state;
            o_RX_DV        <= 1'b0;
            o_RX_Frame_Err <= 1'b0;
            case (state)
                RX_START_BIT: begin
                    if (clk_count == HALF_CNT) begin
                        clk_count <= '0;
                        if (!rx_s) o_RX_Active <= 1'b1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                RX_DATA_BITS: begin
                    if (clk_count == LAST_CNT) begin
                        clk_count            <= '0;
                        shift_reg[bit_index] <= rx_s;
                        bit_index            <= (bit_index == LAST_BIT) ? 3'd0 : bit_index + 3'd1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                RX_STOP_BIT: begin
                    if (clk_count == LAST_CNT) begin
                        clk_count   <= '0;
                        o_RX_Active <= 1'b0;
                        if (rx_s) begin
                            o_RX_Byte <= shift_reg;
                            o_RX_DV   <= 1'b1;
                        end else begin
                            o_RX_Frame_Err <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                default: begin
                    clk_count <= '0;
                    bit_index <= '0;
                end
            endcase
        end
    end

endmodule
